// File: rtl/pipeline_idr_skid_stage_if.sv
// Handshake and operand bus between IDC, the ID->EX skid stage and EX.
// Upstream entry, regfile data, forwarding bus and downstream head entry.
interface pipeline_idr_skid_stage_if #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 32,
    parameter int NFWD   = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic                   in_rs1_used;
    logic                   in_rs2_used;
    logic [CTRL_W-1:0]      in_ctrl;
    logic [XLEN-1:0]        rf_rdata1;
    logic [XLEN-1:0]        rf_rdata2;
    logic [NFWD-1:0]        fwd_valid;
    logic [5*NFWD-1:0]      fwd_rd;
    logic [XLEN*NFWD-1:0]   fwd_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_op1;
    logic [XLEN-1:0]        out_op2;
    logic [4:0]             out_rs1;
    logic [4:0]             out_rs2;
    logic [CTRL_W-1:0]      out_ctrl;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rs1_used,
        output in_rs2_used, in_ctrl, rf_rdata1, rf_rdata2,
        output fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, out_pc, out_op1, out_op2,
        input  out_rs1, out_rs2, out_ctrl
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_used,
        input  in_rs2_used, in_ctrl, rf_rdata1, rf_rdata2,
        input  fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, out_pc, out_op1, out_op2,
        output out_rs1, out_rs2, out_ctrl
    );
endinterface

// File: rtl/pipeline_idr_skid_stage.sv
// ID->EX register-read stage: 2-entry skid buffer with operand forwarding/snoop.
// Optional PIPE_IDR_PERF_EN adds stall_cnt/bubble_cnt performance counters.
module pipeline_idr_skid_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 32,
    parameter int NFWD   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    pipeline_idr_skid_stage_if.slave    bus
`ifdef PIPE_IDR_PERF_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 bubble_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              u1;
        logic              u2;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    logic [1:0] r_count;
    logic       r_live;
    entry_t     r_e0;
    entry_t     r_e1;

    entry_t     w_new;
    entry_t     w_new_s;
    entry_t     w_e0s;
    entry_t     w_e1s;
    entry_t     w_e0_n;
    entry_t     w_e1_n;
    logic [1:0] w_cnt_n;
    logic       w_acc;
    logic       w_drn;
    logic       w_ovalid;
    logic       w_iready;

    // Descending scan so the youngest matching source is applied last.
    function automatic entry_t f_snoop(
        input entry_t                 e,
        input logic [NFWD-1:0]        v,
        input logic [5*NFWD-1:0]      rd,
        input logic [XLEN*NFWD-1:0]   d
    );
        entry_t r;
        r = e;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (e.u1 && e.rs1 != 5'd0 && v[i] && rd[5*i+:5] == e.rs1)
                r.op1 = d[XLEN*i+:XLEN];
            if (e.u2 && e.rs2 != 5'd0 && v[i] && rd[5*i+:5] == e.rs2)
                r.op2 = d[XLEN*i+:XLEN];
        end
        return r;
    endfunction

    assign w_ovalid = (r_count != 2'd0);
    assign w_iready = r_live & (r_count != 2'd2);
    assign w_acc    = bus.in_valid & w_iready;
    assign w_drn    = w_ovalid & bus.out_ready;

    always_comb begin
        w_new      = '0;
        w_new.pc   = bus.in_pc;
        w_new.op1  = bus.rf_rdata1;
        w_new.op2  = bus.rf_rdata2;
        w_new.rs1  = bus.in_rs1;
        w_new.rs2  = bus.in_rs2;
        w_new.u1   = bus.in_rs1_used;
        w_new.u2   = bus.in_rs2_used;
        w_new.ctrl = bus.in_ctrl;
        w_new_s    = f_snoop(w_new, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    end

    always_comb begin
        w_e0s = r_e0;
        w_e1s = r_e1;
        if (r_count != 2'd0)
            w_e0s = f_snoop(r_e0, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        if (r_count == 2'd2)
            w_e1s = f_snoop(r_e1, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    end

    // Empty slots stay zero so E0 doubles as the bubble encoding.
    always_comb begin
        w_e0_n  = w_e0s;
        w_e1_n  = w_e1s;
        w_cnt_n = r_count;
        if (w_drn) begin
            w_e0_n  = w_e1s;
            w_e1_n  = '0;
            w_cnt_n = r_count - 2'd1;
        end
        if (w_acc) begin
            if (w_cnt_n == 2'd0)
                w_e0_n = w_new_s;
            else
                w_e1_n = w_new_s;
            w_cnt_n = w_cnt_n + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 2'd0;
            r_live  <= 1'b0;
            r_e0    <= '0;
            r_e1    <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
            r_live  <= 1'b1;
            r_e0    <= '0;
            r_e1    <= '0;
        end else begin
            r_count <= w_cnt_n;
            r_live  <= 1'b1;
            r_e0    <= w_e0_n;
            r_e1    <= w_e1_n;
        end
    end

    assign bus.in_ready  = w_iready;
    assign bus.out_valid = w_ovalid;
    assign bus.out_pc    = r_e0.pc;
    assign bus.out_op1   = r_e0.op1;
    assign bus.out_op2   = r_e0.op2;
    assign bus.out_rs1   = r_e0.rs1;
    assign bus.out_rs2   = r_e0.rs2;
    assign bus.out_ctrl  = r_e0.ctrl;

`ifdef PIPE_IDR_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_ovalid && !bus.out_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!w_ovalid && !flush)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipeline_idr_skid_stage.sv
// Bench for pipeline_idr_skid_stage: vector table, directed corners,
// and randomized traffic against a queue-based reference model.
module tb_pipeline_idr_skid_stage;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 32;
    localparam int NFWD   = 3;

    logic clk;
    logic reset;
    logic flush;
`ifdef PIPE_IDR_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    pipeline_idr_skid_stage_if #(
        .XLEN(XLEN), .CTRL_W(CTRL_W), .NFWD(NFWD)
    ) bus ();

    pipeline_idr_skid_stage #(
        .XLEN(XLEN), .CTRL_W(CTRL_W), .NFWD(NFWD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus)
`ifdef PIPE_IDR_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.in_pc       = '0;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.in_rs1_used = 1'b0;
        bus.in_rs2_used = 1'b0;
        bus.in_ctrl     = '0;
        bus.rf_rdata1   = '0;
        bus.rf_rdata2   = '0;
        bus.fwd_valid   = '0;
        bus.fwd_rd      = '0;
        bus.fwd_data    = '0;
    endtask

    task automatic chk_bubble(input string nm);
        chk({nm, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({nm, "_pc"}, bus.out_pc, 64'd0);
        chk({nm, "_op1"}, bus.out_op1, 64'd0);
        chk({nm, "_op2"}, bus.out_op2, 64'd0);
        chk({nm, "_rs"}, {54'd0, bus.out_rs1, bus.out_rs2}, 64'd0);
        chk({nm, "_ctrl"}, {32'd0, bus.out_ctrl}, 64'd0);
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [63:0] rf1;
        logic [63:0] rf2;
        logic [2:0]  fv;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] e_op1;
        logic [63:0] e_op2;
    } vec_t;

    vec_t tbl[6];

    typedef struct {
        logic [63:0] pc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [31:0] ctrl;
    } m_t;

    m_t q[$];

    // Reference forwarding rule: first (youngest) matching source wins.
    function automatic logic [63:0] m_pick(input logic [4:0] rs,
                                           input logic used,
                                           input logic [63:0] cur);
        if (!used || rs == 5'd0) return cur;
        for (int i = 0; i < NFWD; i++) begin
            if (bus.fwd_valid[i] && bus.fwd_rd[5*i+:5] == rs)
                return bus.fwd_data[XLEN*i+:XLEN];
        end
        return cur;
    endfunction

    task automatic model_step();
        m_t  ne;
        bit  drn;
        bit  acc;
        drn = (q.size() != 0) && bus.out_ready;
        acc = bus.in_valid && (q.size() < 2);
        if (flush) begin
            q.delete();
        end else begin
            foreach (q[j]) begin
                q[j].op1 = m_pick(q[j].rs1, q[j].u1, q[j].op1);
                q[j].op2 = m_pick(q[j].rs2, q[j].u2, q[j].op2);
            end
            if (drn) void'(q.pop_front());
            if (acc) begin
                ne.pc   = bus.in_pc;
                ne.rs1  = bus.in_rs1;
                ne.rs2  = bus.in_rs2;
                ne.u1   = bus.in_rs1_used;
                ne.u2   = bus.in_rs2_used;
                ne.ctrl = bus.in_ctrl;
                ne.op1  = m_pick(ne.rs1, ne.u1, bus.rf_rdata1);
                ne.op2  = m_pick(ne.rs2, ne.u2, bus.rf_rdata2);
                q.push_back(ne);
            end
        end
    endtask

    initial begin
        tbl[0] = '{64'h100, 5'd1, 5'd2, 1'b1, 1'b1, 64'h11, 64'h22,
                   3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0,
                   64'h11, 64'h22};
        tbl[1] = '{64'h104, 5'd3, 5'd0, 1'b0, 1'b1, 64'h33, 64'h44,
                   3'b001, 5'd3, 5'd0, 5'd0, 64'h99, 64'h0, 64'h0,
                   64'h33, 64'h44};
        tbl[2] = '{64'h108, 5'd5, 5'd5, 1'b1, 1'b1, 64'h77, 64'h66,
                   3'b110, 5'd0, 5'd5, 5'd5, 64'h0, 64'hAA, 64'hBB,
                   64'hAA, 64'hAA};
        tbl[3] = '{64'h10C, 5'd0, 5'd5, 1'b1, 1'b0, 64'h55, 64'h66,
                   3'b110, 5'd0, 5'd5, 5'd5, 64'h0, 64'hAA, 64'hBB,
                   64'h55, 64'h66};
        tbl[4] = '{64'h110, 5'd9, 5'd9, 1'b1, 1'b1, 64'h1, 64'h2,
                   3'b111, 5'd9, 5'd9, 5'd9, 64'hC0, 64'hC1, 64'hC2,
                   64'hC0, 64'hC0};
        tbl[5] = '{64'h114, 5'd9, 5'd1, 1'b1, 1'b1, 64'h3, 64'h1,
                   3'b100, 5'd0, 5'd0, 5'd9, 64'h0, 64'h0, 64'hD2,
                   64'hD2, 64'h1};

        idle();
        flush = 1'b0;
        reset = 1'b0;
        step();
        step();
        chk_bubble("rst");
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        reset = 1'b1;
        step();
        chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rel_valid", {63'd0, bus.out_valid}, 64'd0);

        // Streaming table with forwarding cases
        for (int k = 0; k < 6; k++) begin
            bus.in_valid    = 1'b1;
            bus.out_ready   = 1'b1;
            bus.in_pc       = tbl[k].pc;
            bus.in_rs1      = tbl[k].rs1;
            bus.in_rs2      = tbl[k].rs2;
            bus.in_rs1_used = tbl[k].u1;
            bus.in_rs2_used = tbl[k].u2;
            bus.in_ctrl     = tbl[k].pc[31:0] ^ 32'hC0DE0000;
            bus.rf_rdata1   = tbl[k].rf1;
            bus.rf_rdata2   = tbl[k].rf2;
            bus.fwd_valid   = tbl[k].fv;
            bus.fwd_rd      = {tbl[k].rd2, tbl[k].rd1, tbl[k].rd0};
            bus.fwd_data    = {tbl[k].d2, tbl[k].d1, tbl[k].d0};
            step();
            chk($sformatf("tbl%0d_valid", k), {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("tbl%0d_ready", k), {63'd0, bus.in_ready}, 64'd1);
            chk($sformatf("tbl%0d_pc", k), bus.out_pc, tbl[k].pc);
            chk($sformatf("tbl%0d_op1", k), bus.out_op1, tbl[k].e_op1);
            chk($sformatf("tbl%0d_op2", k), bus.out_op2, tbl[k].e_op2);
            chk($sformatf("tbl%0d_ctrl", k), {32'd0, bus.out_ctrl},
                {32'd0, tbl[k].pc[31:0] ^ 32'hC0DE0000});
        end
        idle();
        bus.out_ready = 1'b1;
        step();
        chk_bubble("drain");

        // Backpressure: third entry must wait upstream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 64'h200;
        step();
        chk("bp1_pc", bus.out_pc, 64'h200);
        chk("bp1_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_pc = 64'h204;
        step();
        chk("bp2_ready", {63'd0, bus.in_ready}, 64'd0);
        bus.in_pc = 64'h208;
        step();
        chk("bp3_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("bp3_pc", bus.out_pc, 64'h200);
        bus.out_ready = 1'b1;
        step();
        chk("bp4_pc", bus.out_pc, 64'h204);
        chk("bp4_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        chk("bp5_pc", bus.out_pc, 64'h208);
        bus.in_valid = 1'b0;
        step();
        chk_bubble("bp6");

        // Snoop while held
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_pc       = 64'h300;
        bus.in_rs2      = 5'd7;
        bus.in_rs2_used = 1'b1;
        bus.rf_rdata2   = 64'h50;
        step();
        chk("snp0_op2", bus.out_op2, 64'h50);
        bus.in_valid  = 1'b0;
        bus.fwd_valid = 3'b001;
        bus.fwd_rd    = {5'd0, 5'd0, 5'd7};
        bus.fwd_data  = {64'h0, 64'h0, 64'h1234};
        step();
        chk("snp1_op2", bus.out_op2, 64'h1234);
        chk("snp1_pc", bus.out_pc, 64'h300);
        bus.fwd_valid = 3'b000;
        step();
        chk("snp2_op2", bus.out_op2, 64'h1234);
        bus.out_ready = 1'b1;
        step();
        chk_bubble("snp3");

        // Flush mid-hold with a concurrent offer
        idle();
        bus.in_valid = 1'b1;
        bus.in_pc    = 64'h400;
        step();
        bus.in_pc = 64'h404;
        step();
        chk("fl_full_ready", {63'd0, bus.in_ready}, 64'd0);
        flush        = 1'b1;
        bus.in_pc    = 64'h408;
        step();
        chk_bubble("fl");
        chk("fl_ready", {63'd0, bus.in_ready}, 64'd1);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("fl2_valid", {63'd0, bus.out_valid}, 64'd0);

        // Reset mid-stream
        bus.in_valid = 1'b1;
        bus.in_pc    = 64'h500;
        bus.in_ctrl  = 32'hDEAD;
        step();
        chk("rm_valid", {63'd0, bus.out_valid}, 64'd1);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk_bubble("rm");
        chk("rm_ready", {63'd0, bus.in_ready}, 64'd0);
        reset = 1'b1;
        step();
        chk("rm_rel_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rm_rel_valid", {63'd0, bus.out_valid}, 64'd0);

        // Randomized traffic against the queue model
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            m_t h;
            h = '{default: '0};
            if (q.size() != 0) h = q[0];
            chk("rnd_valid", {63'd0, bus.out_valid},
                {63'd0, q.size() != 0});
            chk("rnd_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
            chk("rnd_pc", bus.out_pc, h.pc);
            chk("rnd_op1", bus.out_op1, h.op1);
            chk("rnd_op2", bus.out_op2, h.op2);
            chk("rnd_rs", {54'd0, bus.out_rs1, bus.out_rs2},
                {54'd0, h.rs1, h.rs2});
            chk("rnd_ctrl", {32'd0, bus.out_ctrl}, {32'd0, h.ctrl});
            bus.in_valid    = ($urandom % 4) != 0;
            bus.out_ready   = ($urandom % 3) != 0;
            flush           = ($urandom % 40) == 0;
            bus.in_pc       = {$urandom, $urandom};
            bus.in_rs1      = 5'($urandom_range(0, 7));
            bus.in_rs2      = 5'($urandom_range(0, 7));
            bus.in_rs1_used = 1'($urandom);
            bus.in_rs2_used = 1'($urandom);
            bus.in_ctrl     = $urandom;
            bus.rf_rdata1   = {$urandom, $urandom};
            bus.rf_rdata2   = {$urandom, $urandom};
            bus.fwd_valid   = 3'($urandom);
            for (int i = 0; i < NFWD; i++) begin
                bus.fwd_rd[5*i+:5]        = 5'($urandom_range(0, 7));
                bus.fwd_data[XLEN*i+:XLEN] = {$urandom, $urandom};
            end
            model_step();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
